sha256_hashing_stream_multi: RTL and testbench



---
 rtl/sha256_hashing_stream_multi.sv | 255 +++++++++++++++++++++++++
 tb/tb_sha256_hashing_stream_multi.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_hashing_stream_multi.sv
// Multi-engine SHA-256 stream: whole messages go round-robin to compression engines, digests leave in arrival order.
// Optional status ports are enabled with `define SHA256_MULTI_STATUS_EN.
module sha256_hash_compression (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync_rst,
    input  logic [511:0] in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] out_data,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state_q;
    logic [5:0]  rnd_q;
    logic        last_q;
    logic [31:0] hv_q [8];
    logic [31:0] wk_q [8];
    logic [31:0] w_q  [16];
    logic [31:0] wk_d [8];
    logic [31:0] w_new_d;
    logic [31:0] t1, t2;

    always_comb begin
        t1 = wk_q[7] + (rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25))
           + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6])) + K[rnd_q] + w_q[0];
        t2 = (rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22))
           + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
        wk_d[0] = t1 + t2;
        wk_d[1] = wk_q[0];
        wk_d[2] = wk_q[1];
        wk_d[3] = wk_q[2];
        wk_d[4] = wk_q[3] + t1;
        wk_d[5] = wk_q[4];
        wk_d[6] = wk_q[5];
        wk_d[7] = wk_q[6];
        w_new_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    // A finished digest can be handed off and a new message started in the same cycle.
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid = (state_q == S_DONE);
    assign out_last  = (state_q == S_DONE) & last_q;
    assign out_data  = {hv_q[0], hv_q[1], hv_q[2], hv_q[3], hv_q[4], hv_q[5], hv_q[6], hv_q[7]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv_q[i] <= IV[i];
                wk_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (sync_rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv_q[i] <= IV[i];
                wk_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (en) begin
            case (state_q)
                S_RUN: begin
                    for (int i = 0; i < 8; i++) wk_q[i] <= wk_d[i];
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                    w_q[15] <= w_new_d;
                    rnd_q   <= rnd_q + 6'd1;
                    if (rnd_q == 6'd63) begin
                        for (int i = 0; i < 8; i++) hv_q[i] <= hv_q[i] + wk_d[i];
                        state_q <= last_q ? S_DONE : S_IDLE;
                    end
                end
                default: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < 8; i++) begin
                            wk_q[i] <= (state_q == S_DONE) ? IV[i] : hv_q[i];
                            if (state_q == S_DONE) hv_q[i] <= IV[i];
                        end
                        for (int i = 0; i < 16; i++) w_q[i] <= in_data[511 - 32*i -: 32];
                        rnd_q   <= '0;
                        last_q  <= in_last;
                        state_q <= S_RUN;
                    end else if (state_q == S_DONE && out_ready) begin
                        for (int i = 0; i < 8; i++) hv_q[i] <= IV[i];
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

module sha256_hashing_stream_multi #(
    parameter int NUM_ENGINES = 4,
    parameter int ORDER_DEPTH = 8,
    parameter int ID_W        = 6
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic            sync_rst,
`ifdef SHA256_MULTI_STATUS_EN
    output logic [$clog2(ORDER_DEPTH):0] status_inflight,
    output logic [31:0]     status_msgs_in,
    output logic [31:0]     status_msgs_out,
`endif
    input  logic [511:0]    data_in,
    input  logic            data_in_last,
    input  logic            data_in_valid,
    output logic            data_in_ready,
    output logic [255:0]    data_out,
    output logic            data_out_last,
    output logic [ID_W-1:0] data_out_id,
    output logic            data_out_valid,
    input  logic            data_out_ready
);
    localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int AW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

    logic [EW-1:0]   cur_eng_q;
    logic            in_msg_q;
    logic [ID_W-1:0] id_cnt_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]   ord_eng_q [2**AW];
    logic [ID_W-1:0] ord_id_q  [2**AW];

    logic [AW:0]     occ;
    logic            order_empty, order_full;
    logic [EW-1:0]   head_eng;
    logic [ID_W-1:0] head_id;
    logic            pop, acc, push;

    logic [NUM_ENGINES-1:0] eng_in_ready, eng_in_valid, eng_out_valid, eng_out_ready, eng_out_last;
    logic [255:0]           eng_out_data [NUM_ENGINES];

    assign occ         = wr_ptr_q - rd_ptr_q;
    assign order_empty = (occ == '0);
    assign order_full  = (occ == (AW+1)'(ORDER_DEPTH));
    assign head_eng    = ord_eng_q[rd_ptr_q[AW-1:0]];
    assign head_id     = ord_id_q[rd_ptr_q[AW-1:0]];

    assign data_out_valid = ~order_empty & eng_out_valid[head_eng];
    assign data_out       = data_out_valid ? eng_out_data[head_eng] : '0;
    assign data_out_last  = data_out_valid & eng_out_last[head_eng];
    assign data_out_id    = data_out_valid ? head_id : '0;
    assign pop            = data_out_valid & data_out_ready & en & ~sync_rst;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a new message start.
    assign data_in_ready = nrst & en & ~sync_rst & eng_in_ready[cur_eng_q] & (in_msg_q | ~order_full | pop);
    assign acc           = data_in_valid & data_in_ready;
    assign push          = acc & ~in_msg_q;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        assign eng_in_valid[g]  = acc & (cur_eng_q == EW'(g));
        assign eng_out_ready[g] = data_out_ready & ~order_empty & en & ~sync_rst & (head_eng == EW'(g));

        sha256_hash_compression u_eng (
            .clk       (clk),
            .nrst      (nrst),
            .en        (en),
            .sync_rst  (sync_rst),
            .in_data   (data_in),
            .in_last   (data_in_last),
            .in_valid  (eng_in_valid[g]),
            .in_ready  (eng_in_ready[g]),
            .out_data  (eng_out_data[g]),
            .out_last  (eng_out_last[g]),
            .out_valid (eng_out_valid[g]),
            .out_ready (eng_out_ready[g])
        );
    end

`ifdef SHA256_MULTI_STATUS_EN
    logic [31:0] msgs_in_q, msgs_out_q;
    assign status_inflight = ($clog2(ORDER_DEPTH)+1)'(occ);
    assign status_msgs_in  = msgs_in_q;
    assign status_msgs_out = msgs_out_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            msgs_in_q  <= '0;
            msgs_out_q <= '0;
        end else if (sync_rst) begin
            msgs_in_q  <= '0;
            msgs_out_q <= '0;
        end else if (en) begin
            if (push) msgs_in_q  <= msgs_in_q + 32'd1;
            if (pop)  msgs_out_q <= msgs_out_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur_eng_q <= '0;
            in_msg_q  <= 1'b0;
            id_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                ord_eng_q[i] <= '0;
                ord_id_q[i]  <= '0;
            end
        end else if (sync_rst) begin
            cur_eng_q <= '0;
            in_msg_q  <= 1'b0;
            id_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                ord_eng_q[i] <= '0;
                ord_id_q[i]  <= '0;
            end
        end else if (en) begin
            if (push) begin
                ord_eng_q[wr_ptr_q[AW-1:0]] <= cur_eng_q;
                ord_id_q[wr_ptr_q[AW-1:0]]  <= id_cnt_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
                id_cnt_q <= id_cnt_q + 1'b1;
                in_msg_q <= 1'b1;
            end
            if (acc && data_in_last) begin
                in_msg_q  <= 1'b0;
                cur_eng_q <= (cur_eng_q == EW'(NUM_ENGINES - 1)) ? '0 : cur_eng_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_sha256_hashing_stream_multi.sv
// Randomised and directed bench for sha256_hashing_stream_multi against a block-level SHA-256 reference.
module tb_sha256_hashing_stream_multi;
    localparam int NE  = 8;
    localparam int OD  = 8;
    localparam int IDW = 2;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] IV_ALL  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic nrst, en, sync_rst;
    logic [511:0] data_in;
    logic data_in_last, data_in_valid, data_in_ready;
    logic [255:0] data_out;
    logic data_out_last, data_out_valid, data_out_ready;
    logic [IDW-1:0] data_out_id;

    sha256_hashing_stream_multi #(.NUM_ENGINES(NE), .ORDER_DEPTH(OD), .ID_W(IDW)) dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out), .data_out_last(data_out_last),
        .data_out_id(data_out_id), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression of one 512-bit block onto a chaining value.
    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    typedef struct { logic [255:0] dig; int id; } exp_t;
    exp_t exp_q[$];
    logic [255:0] run_h = IV_ALL;
    bit in_msg_m = 0;
    int id_m = 0, cur_id = 0;
    int got_id[$];
    logic [255:0] got_dig[$];

    // Reference: digests queued in acceptance order, checked whenever the DUT presents one.
    always @(negedge clk) begin
        if (!nrst || sync_rst) begin
            exp_q.delete(); in_msg_m = 0; id_m = 0; run_h = IV_ALL;
        end else begin
            automatic bit ohs = data_out_valid & data_out_ready & en;
            if (data_out_valid) begin
                if (exp_q.size() == 0) chk("out_unexpected_valid", data_out_valid, 0);
                else begin
                    chk("out_dig", data_out, exp_q[0].dig);
                    chk("out_id", data_out_id, exp_q[0].id);
                    chk("out_last", data_out_last, 1);
                end
            end
            if (!en) chk("ready_when_en_low", data_in_ready, 0);
            else if (!in_msg_m && exp_q.size() == OD && !ohs) chk("ready_when_full", data_in_ready, 0);
            if (ohs && exp_q.size() > 0) begin
                got_id.push_back(exp_q[0].id);
                got_dig.push_back(data_out);
                void'(exp_q.pop_front());
            end
            if (en && data_in_valid && data_in_ready) begin
                if (!in_msg_m) begin
                    run_h = IV_ALL; cur_id = id_m; id_m = (id_m + 1) % (1 << IDW); in_msg_m = 1;
                end
                run_h = sha_blk(run_h, data_in);
                if (data_in_last) begin
                    exp_q.push_back('{dig: run_h, id: cur_id});
                    in_msg_m = 0;
                end
            end
        end
    end

    bit rand_sink = 0, rand_en = 0;
    always @(posedge clk) begin
        #1;
        if (rand_sink) data_out_ready = ($urandom_range(0, 3) != 0);
        if (rand_en)   en = ($urandom_range(0, 7) != 0);
    end

    int acc_cyc;
    task automatic send_blk(input logic [511:0] b, input bit last);
        int c;
        data_in = b; data_in_last = last; data_in_valid = 1'b1;
        for (c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (data_in_ready) break;
        end
        if (c == 5000) chk("send_timeout", c, 0);
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 5000 && got_id.size() < n; c++) @(posedge clk);
        #1;
        chk("outputs_seen", got_id.size(), n);
    endtask

    task automatic do_sync_rst();
        data_in_valid = 1'b0;
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        got_id.delete(); got_dig.delete();
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom();
        return b;
    endfunction

    logic [511:0] abc_blk;
    int t0, nb;

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0; data_in = '0; data_in_last = 1'b0;
        data_in_valid = 1'b0; data_out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", data_in_ready, 0);
        chk("rst_out_valid", data_out_valid, 0);
        chk("rst_out_data", data_out, 0);
        chk("rst_out_id", data_out_id, 0);
        chk("rst_out_last", data_out_last, 0);
        chk("model_abc", sha_blk(IV_ALL, abc_blk), ABC_DIG);
        nrst = 1'b1;
        @(posedge clk); #1;

        // single "abc"
        data_out_ready = 1'b1;
        send_blk(abc_blk, 1); data_in_valid = 1'b0;
        wait_out(1);
        chk("abc_digest", got_dig[0], ABC_DIG);
        chk("abc_id", got_id[0], 0);

        // four back-to-back "abc" messages
        do_sync_rst();
        send_blk(abc_blk, 1); t0 = acc_cyc;
        for (int i = 1; i < 4; i++) send_blk(abc_blk, 1);
        data_in_valid = 1'b0;
        chk("b2b_accept_cycles", acc_cyc - t0, 3);
        wait_out(4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_id", got_id[i], i);
            chk("b2b_digest", got_dig[i], ABC_DIG);
        end

        // 3-block message A then single-block message B
        do_sync_rst();
        for (int i = 0; i < 3; i++) send_blk(rnd_blk(), i == 2);
        send_blk(rnd_blk(), 1); data_in_valid = 1'b0;
        wait_out(2);
        chk("order_first_id", got_id[0], 0);
        chk("order_second_id", got_id[1], 1);

        // fill the order FIFO with the sink stalled
        do_sync_rst();
        data_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_blk(rnd_blk(), 1);
        data_in = rnd_blk(); data_in_last = 1'b1; data_in_valid = 1'b1;
        repeat (80) @(negedge clk);
        chk("full_stall_ready", data_in_ready, 0);
        chk("full_head_valid", data_out_valid, 1);
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_accept", data_in_ready, 1);
        @(posedge clk); #1;
        data_out_ready = 1'b0; data_in_valid = 1'b0;
        @(negedge clk);
        chk("full_again", data_in_ready, 0);
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        wait_out(9);
        for (int i = 0; i < 9; i++) chk("wrap_id", got_id[i], i % 4);

        // sync_rst in the middle of a 3-block message
        do_sync_rst();
        send_blk(rnd_blk(), 0); send_blk(rnd_blk(), 0);
        data_in_valid = 1'b0; sync_rst = 1'b1;
        @(negedge clk);
        chk("srst_in_ready", data_in_ready, 0);
        @(posedge clk); #1;
        sync_rst = 1'b0; got_id.delete(); got_dig.delete();
        @(negedge clk);
        chk("srst_out_valid", data_out_valid, 0);
        @(posedge clk); #1;
        send_blk(abc_blk, 1); data_in_valid = 1'b0;
        wait_out(1);
        chk("srst_abc_id", got_id[0], 0);
        chk("srst_abc_digest", got_dig[0], ABC_DIG);

        // ID wrap over five messages
        do_sync_rst();
        for (int i = 0; i < 5; i++) send_blk(abc_blk, 1);
        data_in_valid = 1'b0;
        wait_out(5);
        for (int i = 0; i < 5; i++) chk("idwrap_id", got_id[i], i % 4);

        // random traffic with random sink stalls and enable drops
        do_sync_rst();
        rand_sink = 1; rand_en = 1;
        for (int m = 0; m < 40; m++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send_blk(rnd_blk(), b == nb - 1);
            end
        end
        data_in_valid = 1'b0;
        rand_sink = 0; rand_en = 0;
        @(posedge clk); #2;
        en = 1'b1; data_out_ready = 1'b1;
        wait_out(40);
        chk("random_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
